// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: state encoding and default widths.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc.sv
// Word program counter: a load takes priority over an increment, and the count wraps
// modulo 2**ADDR_W.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a redirect load wins over the sequential step; natural overflow wraps to 0.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register, returns to the reset address asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : fetch_pc

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: sequences the instruction ROM, captures the returned word
// into an output register and hands it to decode over valid/ready, with halt, backpressure
// and redirect-with-flush.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INST_W   = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc;
  logic              advance;

  logic              outValid_q;
  logic              outValid_d;
  logic [INST_W-1:0] outInst_q;
  logic [INST_W-1:0] outInst_d;
  logic [ADDR_W-1:0] outPc_q;
  logic [ADDR_W-1:0] outPc_d;

  // A fetch starts only in FETCH, with no halt or redirect, and only when the output
  // register is empty or being consumed this cycle.
  assign advance  = (state_q == FETCH) & ~halt & ~redirect_valid & (~outValid_q | out_ready);
  assign rom_ce   = advance;
  assign rom_addr = pc;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (advance),
    .load     (redirect_valid),
    .load_val (redirect_pc),
    .pc       (pc)
  );

  // Next state follows halt alone; a redirect never alters the state transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = halt ? HALTED : FETCH;
      FETCH:   if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register next value: a redirect flushes, an advance captures the ROM word,
  // and a bare handshake empties the register while keeping the last data visible.
  always_comb begin
    outValid_d = outValid_q;
    outInst_d  = outInst_q;
    outPc_d    = outPc_q;
    if (redirect_valid) begin
      outValid_d = 1'b0;
    end else if (advance) begin
      outValid_d = 1'b1;
      outInst_d  = rom_inst;
      outPc_d    = pc;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output register; reset discards any pending instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outInst_q  <= '0;
      outPc_q    <= '0;
    end else begin
      outValid_q <= outValid_d;
      outInst_q  <= outInst_d;
      outPc_q    <= outPc_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_inst  = outInst_q;
  assign out_pc    = outPc_q;

endmodule : inst_fetch_ctrl

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_inst_fetch_ctrl;

  localparam int ADDR_W = 6;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  int checks = 0;
  int errors = 0;

  // Model state: what the fetch unit must look like from the outside.
  logic [ADDR_W-1:0] mPc;
  logic [ADDR_W-1:0] mOutPc;
  logic [INST_W-1:0] mOutInst;
  bit                mOutValid;
  bit                mStarted;
  bit                mPrevHalt;

  inst_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] romWord(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + {26'd0, a};
  endfunction

  // ROM model; returns garbage when not enabled so an unguarded capture shows up.
  assign rom_inst = rom_ce ? romWord(rom_addr) : 32'hDEAD_BEEF;

  function automatic bit modelAdvance();
    return mStarted && !mPrevHalt && !halt && !redirect_valid && (!mOutValid || out_ready);
  endfunction

  task automatic modelReset();
    mPc       = '0;
    mOutPc    = '0;
    mOutInst  = '0;
    mOutValid = 1'b0;
    mStarted  = 1'b0;
    mPrevHalt = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkAll();
    checkOutput("rom_ce",    {31'd0, rom_ce},     {31'd0, modelAdvance()});
    checkOutput("rom_addr",  {26'd0, rom_addr},   {26'd0, mPc});
    checkOutput("out_valid", {31'd0, out_valid},  {31'd0, mOutValid});
    checkOutput("out_inst",  out_inst,            mOutInst);
    checkOutput("out_pc",    {26'd0, out_pc},     {26'd0, mOutPc});
  endtask

  // Drive inputs for this cycle, then compare mid-cycle.
  task automatic applyStimulus(input bit h, input bit rdy, input bit rv, input logic [ADDR_W-1:0] rpc);
    halt           = h;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    checkAll();
  endtask

  // Advance the model across the coming rising edge, then step past it.
  task automatic finishCycle();
    bit adv;
    adv = modelAdvance();
    if (redirect_valid) begin
      mPc       = redirect_pc;
      mOutValid = 1'b0;
    end else if (adv) begin
      mOutInst  = romWord(mPc);
      mOutPc    = mPc;
      mOutValid = 1'b1;
      mPc       = mPc + 1'b1;
    end else if (mOutValid && out_ready) begin
      mOutValid = 1'b0;
    end
    mStarted  = 1'b1;
    mPrevHalt = halt;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input bit h, input bit rdy, input bit rv, input logic [ADDR_W-1:0] rpc);
    applyStimulus(h, rdy, rv, rpc);
    finishCycle();
  endtask

  // Free-run with ready high until the model shows the wanted out_pc valid.
  task automatic runUntilOutPc(input logic [ADDR_W-1:0] target);
    int n;
    n = 0;
    while (!(mOutValid && mOutPc == target) && n < 200) begin
      runCycle(1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL wait_out_pc: timed out waiting for out_pc %0d", target);
    end
  endtask

  initial begin
    modelReset();
    // Reset values while rst_n held low.
    @(negedge clk);
    checkAll();
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_rom_ce",    {31'd0, rom_ce},    32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Scenario 1: first cycle idle, then one instruction per cycle from address 0.
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s1_cycle1_rom_ce", {31'd0, rom_ce}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s1_cycle2_rom_ce",   {31'd0, rom_ce},   32'd1);
    checkOutput("s1_cycle2_rom_addr", {26'd0, rom_addr}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s1_first_inst", out_inst, 32'hA000_0000);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s1_second_inst", out_inst, 32'hA000_0001);
    finishCycle();

    // Scenario 2: backpressure with out_pc=5 held for three cycles.
    runUntilOutPc(6'd5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("s2_hold_out_pc",   {26'd0, out_pc},   32'd5);
      checkOutput("s2_hold_rom_ce",   {31'd0, rom_ce},   32'd0);
      checkOutput("s2_hold_rom_addr", {26'd0, rom_addr}, 32'd6);
      finishCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s2_release_out_pc", {26'd0, out_pc}, 32'd5);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s2_next_out_pc", {26'd0, out_pc}, 32'd6);
    checkOutput("s2_next_inst",   out_inst,        32'hA000_0006);
    finishCycle();

    // Scenario 3: wrap from 63 to 0.
    runUntilOutPc(6'd62);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s3_out_pc_63", {26'd0, out_pc}, 32'd63);
    checkOutput("s3_inst_3f",   out_inst,        32'hA000_003F);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s3_out_pc_0",  {26'd0, out_pc}, 32'd0);
    checkOutput("s3_inst_0",    out_inst,        32'hA000_0000);
    finishCycle();

    // Scenario 4: redirect to 20 while out_pc=9 is valid.
    runUntilOutPc(6'd9);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd20);
    checkOutput("s4_redir_rom_ce", {31'd0, rom_ce}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s4_flushed_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("s4_new_rom_addr",  {26'd0, rom_addr},  32'd20);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s4_out_pc_20", {26'd0, out_pc}, 32'd20);
    checkOutput("s4_inst_20",   out_inst,        32'hA000_0014);
    finishCycle();

    // Scenario 5: halt for four cycles; 21 drains, pc freezes at 22.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("s5_halt_rom_ce",   {31'd0, rom_ce},   32'd0);
      checkOutput("s5_halt_rom_addr", {26'd0, rom_addr}, 32'd22);
      if (i == 0) checkOutput("s5_drain_out_pc", {26'd0, out_pc}, 32'd21);
      else        checkOutput("s5_halt_valid",   {31'd0, out_valid}, 32'd0);
      finishCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s5_resume_gap_rom_ce", {31'd0, rom_ce}, 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s5_resume_rom_ce",   {31'd0, rom_ce},   32'd1);
    checkOutput("s5_resume_rom_addr", {26'd0, rom_addr}, 32'd22);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s5_resume_inst", out_inst, 32'hA000_0016);
    finishCycle();

    // Scenario 6: asynchronous reset between edges mid-stream.
    runCycle(1'b0, 1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("s6_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("s6_inst",  out_inst,           32'd0);
    checkOutput("s6_pc",    {26'd0, out_pc},    32'd0);
    checkOutput("s6_rom_ce", {31'd0, rom_ce},   32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("s6_refetch_addr", {26'd0, rom_addr}, 32'd0);
    finishCycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      runCycle($urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0,
               ADDR_W'($urandom_range(0, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_inst_fetch_ctrl
